// File: rtl/seg7_decoder.sv
// Receive-side 7-segment decoder: locks onto a pattern stable for STABLE_CYCLES
// accepted samples, then reports a BCD digit, a blank display or an illegal glyph.
module seg7_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg_in,
    input  logic                 seg_valid,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 blank,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 locked
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW:0] StableVal = (CntW + 1)'(STABLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StCount, StLocked} state_e;

    state_e                state_q, state_d;
    logic [6:0]            cand_q, cand_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW:0]         cnt_inc;
    logic [3:0]            digit_q, digit_d;
    logic                  digit_valid_q, digit_valid_d;
    logic                  blank_q, blank_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic                  locked_q;
    logic                  report;
    logic                  dec_legal;
    logic [3:0]            dec_val;

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'd0;
        case (seg_in)
            7'h3F: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5B: dec_val = 4'd2;
            7'h4F: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6D: dec_val = 4'd5;
            7'h7D: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7F: dec_val = 4'd8;
            7'h6F: dec_val = 4'd9;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        report  = 1'b0;
        cnt_inc = {1'b0, cnt_q} + (CntW + 1)'(1);
        if (seg_valid) begin
            // A new candidate either starts a count or, with a one-sample window, locks at once.
            if (state_q == StIdle || seg_in != cand_q) begin
                cand_d = seg_in;
                cnt_d  = CntW'(1);
                if (STABLE_CYCLES == 1) begin
                    report  = 1'b1;
                    state_d = StLocked;
                end else begin
                    state_d = StCount;
                end
            end else if (state_q == StCount) begin
                cnt_d = cnt_inc[CntW-1:0];
                if (cnt_inc == StableVal) begin
                    report  = 1'b1;
                    state_d = StLocked;
                end
            end
        end
    end

    always_comb begin
        digit_d       = digit_q;
        blank_d       = blank_q;
        digit_valid_d = 1'b0;
        err_d         = 1'b0;
        err_count_d   = err_count_q;
        if (report) begin
            if (seg_in == 7'h00) begin
                blank_d = 1'b1;
            end else if (dec_legal) begin
                digit_d       = dec_val;
                digit_valid_d = 1'b1;
                blank_d       = 1'b0;
            end else begin
                err_d = 1'b1;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cand_q        <= 7'h00;
            cnt_q         <= '0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            blank_q       <= 1'b1;
            err_q         <= 1'b0;
            err_count_q   <= '0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
            locked_q      <= (state_d == StLocked);
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign blank       = blank_q;
    assign err         = err_q;
    assign err_count   = err_count_q;
    assign locked      = locked_q;

endmodule
